// File: rtl/gap_fill_scheduler_pkg.sv
// Shared types and sizing for the gap-fill interpolation scheduler.
// Holds channel/sample widths, divider cycle count and the FSM state enum.
package gap_fill_scheduler_pkg;

  localparam int NCH        = 4;
  localparam int W          = 16;
  localparam int DEPTH      = 8;
  localparam int AW         = 3;
  localparam int DIV_CYCLES = W + 1;
  localparam int CHW        = $clog2(NCH);
  localparam int CNTW       = $clog2(DIV_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    EMIT,
    FIN
  } state_t;

  typedef logic [CHW-1:0] ch_t;

endpackage

// File: rtl/gap_fill_scheduler_divider.sv
// Serial restoring divider with floor correction, fixed DIV_CYCLES latency.
// Ports: clk, reset, start (loads operands), dividend (signed W+1),
//   divisor (unsigned AW+1), q (floor quotient), r (0..divisor-1), ready.
module serial_floor_divider
  import gap_fill_scheduler_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic signed [W:0] dividend,
  input  logic [AW:0]       divisor,
  output logic signed [W:0] q,
  output logic [AW:0]       r,
  output logic              ready
);

  logic [W:0]      quo;
  logic [AW:0]     rem;
  logic [AW:0]     dsr;
  logic            neg;
  logic [CNTW-1:0] cnt;
  logic [W:0]      mag;
  logic [AW+1:0]   trial;
  logic [AW+1:0]   diff;
  logic            fits;
  logic [W:0]      quo_p1;

  assign mag    = dividend[W] ? (W+1)'(-dividend)
                              : (W+1)'(dividend);
  assign trial  = {rem, quo[W]};
  assign diff   = trial - {1'b0, dsr};
  assign fits   = trial >= {1'b0, dsr};
  assign quo_p1 = quo + (W+1)'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quo   <= '0;
      rem   <= '0;
      dsr   <= '0;
      neg   <= 1'b0;
      cnt   <= '0;
      ready <= 1'b0;
    end else if (start) begin
      quo   <= mag;
      rem   <= '0;
      dsr   <= divisor;
      neg   <= dividend[W];
      cnt   <= CNTW'(DIV_CYCLES);
      ready <= 1'b0;
    end else if (cnt != '0) begin
      quo   <= {quo[W-1:0], fits};
      rem   <= fits ? diff[AW:0] : trial[AW:0];
      cnt   <= cnt - CNTW'(1);
      ready <= (cnt == CNTW'(1));
    end
  end

  // Magnitude divide, then round toward minus infinity for
  // negative dividends so the remainder is always non-negative.
  always_comb begin
    q = $signed(quo);
    r = rem;
    if (neg && rem != '0) begin
      q = -$signed(quo_p1);
      r = dsr - rem;
    end else if (neg) begin
      q = -$signed(quo);
    end
  end

endmodule

// File: rtl/gap_fill_scheduler.sv
// Round-robin scheduler sharing one exact interpolation engine across channels.
// Ports: clk, reset, req/req_last/req_next/req_gap/req_base (per channel),
//   ack, wr_valid/wr_ch/wr_addr/wr_data (ring write), done, busy.
module gap_fill_scheduler
  import gap_fill_scheduler_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    req,
  input  logic [NCH*W-1:0]  req_last,
  input  logic [NCH*W-1:0]  req_next,
  input  logic [NCH*AW-1:0] req_gap,
  input  logic [NCH*AW-1:0] req_base,
  output logic [NCH-1:0]    ack,
  output logic              wr_valid,
  output logic [1:0]        wr_ch,
  output logic [AW-1:0]     wr_addr,
  output logic [W-1:0]      wr_data,
  output logic [NCH-1:0]    done,
  output logic              busy
);

  state_t state;
  ch_t    rr_ptr;
  ch_t    gnt;
  ch_t    cand;
  ch_t    ch_r;
  logic   gnt_ok;

  logic signed [W-1:0] last_in;
  logic signed [W-1:0] next_in;
  logic signed [W-1:0] last_r;
  logic [AW-1:0]       g_in;
  logic [AW-1:0]       base_in;
  logic [AW-1:0]       g_r;
  logic [AW-1:0]       base_r;
  logic [AW-1:0]       k_r;
  logic signed [W:0]   delta_in;
  logic [AW:0]         den_in;
  logic [AW:0]         den_r;

  logic              div_start;
  logic              div_ready;
  logic signed [W:0] div_q;
  logic [AW:0]       div_r;

  logic signed [W:0] acc_q;
  logic signed [W:0] nq;
  logic [AW:0]       acc_r;
  logic [AW:0]       nr_sum;
  logic [AW:0]       nr;
  logic              wrap;
  logic signed [W:0] last_x;
  logic signed [W:0] first_sum;
  logic signed [W:0] next_sum;

  // First requester at or after rr_ptr; descending scan so the
  // smallest offset is the one that sticks.
  always_comb begin
    gnt    = rr_ptr;
    gnt_ok = 1'b0;
    cand   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      cand = rr_ptr + ch_t'(i);
      if (req[cand]) begin
        gnt    = cand;
        gnt_ok = 1'b1;
      end
    end
  end

  assign last_in  = req_last[gnt*W +: W];
  assign next_in  = req_next[gnt*W +: W];
  assign g_in     = req_gap[gnt*AW +: AW];
  assign base_in  = req_base[gnt*AW +: AW];
  assign delta_in = {next_in[W-1], next_in}
                  - {last_in[W-1], last_in};
  assign den_in   = {1'b0, g_in} + (AW+1)'(1);
  assign den_r    = {1'b0, g_r} + (AW+1)'(1);

  // Divider loads straight from the granted operands in the
  // grant cycle, so it finishes exactly as DIV ends.
  assign div_start = (state == IDLE) && gnt_ok
                   && (g_in != '0);

  serial_floor_divider u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (delta_in),
    .divisor  (den_in),
    .q        (div_q),
    .r        (div_r),
    .ready    (div_ready)
  );

  // Exact step: carry the fractional part as a remainder
  // against g+1 instead of multiplying per sample.
  assign nr_sum    = acc_r + div_r;
  assign wrap      = nr_sum >= den_r;
  assign nr        = wrap ? nr_sum - den_r : nr_sum;
  assign nq        = acc_q + div_q + {{W{1'b0}}, wrap};
  assign last_x    = {last_r[W-1], last_r};
  assign first_sum = last_x + div_q;
  assign next_sum  = last_x + nq;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      ack      <= '0;
      done     <= '0;
      wr_valid <= 1'b0;
      wr_ch    <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      ch_r     <= '0;
      last_r   <= '0;
      g_r      <= '0;
      base_r   <= '0;
      k_r      <= '0;
      acc_q    <= '0;
      acc_r    <= '0;
    end else begin
      ack      <= '0;
      done     <= '0;
      wr_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt_ok) begin
            ack[gnt] <= 1'b1;
            ch_r     <= gnt;
            last_r   <= last_in;
            g_r      <= g_in;
            base_r   <= base_in;
            rr_ptr   <= gnt + ch_t'(1);
            if (g_in == '0) begin
              done[gnt] <= 1'b1;
              state     <= FIN;
            end else begin
              state <= DIV;
            end
          end
        end
        DIV: begin
          if (div_ready) begin
            wr_valid <= 1'b1;
            wr_ch    <= ch_r;
            wr_addr  <= base_r;
            wr_data  <= first_sum[W-1:0];
            acc_q    <= div_q;
            acc_r    <= div_r;
            k_r      <= AW'(1);
            state    <= EMIT;
          end
        end
        EMIT: begin
          if (k_r == g_r) begin
            done[ch_r] <= 1'b1;
            state      <= FIN;
          end else begin
            wr_valid <= 1'b1;
            wr_addr  <= base_r + k_r;
            wr_data  <= next_sum[W-1:0];
            acc_q    <= nq;
            acc_r    <= nr;
            k_r      <= k_r + AW'(1);
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/gap_fill_scheduler.md
Name: gap_fill_scheduler

Overview:
Shares one exact linear-interpolation engine between the NCH channel extrapolation buffers in the 4-channel processing path. Each buffer raises a request when a gap of missed samples has closed, i.e. a valid sample arrives after one or more misses. The block arbitrates round-robin, computes the per-step slope with a serial floor divider, then emits one interpolated sample per cycle as a write into the granted channel's ring buffer. It replaces per-channel combinational division.

Parameters:
NCH, 4, number of requesting channels
W, 16, signed sample width
DEPTH, 8, ring-buffer depth per channel (power of 2)
AW, 3, log2(DEPTH); also the width of the gap count

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req  in  NCH  per-channel gap-fill request; held until ack
req_last  in  NCH*W  signed last valid sample before the gap, per channel
req_next  in  NCH*W  signed first valid sample after the gap, per channel
req_gap  in  NCH*AW  number of missed samples g (0..DEPTH-1), per channel
req_base  in  NCH*AW  ring address of the first missed slot, per channel
ack  out  NCH  one-cycle grant pulse; operands sampled in this cycle
wr_valid  out  1  interpolated write strobe
wr_ch  out  2  channel index of the write
wr_addr  out  AW  ring address of the write
wr_data  out  W  signed interpolated value
done  out  NCH  one-cycle pulse when a channel's gap fill completes
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, active-high):
  - All outputs go to 0 and the FSM goes to IDLE.
  - Round-robin pointer resets so channel 0 has highest priority.
  - Any in-flight fill is discarded; the channel must re-request.
- FSM states: IDLE, DIV, EMIT, FIN.
- IDLE:
  - If any req bit is set, grant the first requester at or after rr_ptr (wrapping).
  - Pulse ack[ch] and latch last, next, g and base.
  - Set rr_ptr to ch+1 mod NCH.
  - If g==0 go to FIN; otherwise go to DIV.
- DIV:
  - Compute delta = next - last as (W+1)-bit signed.
  - Run a restoring divide of |delta| by (g+1): exactly W+1 = 17 cycles, one quotient bit per cycle.
  - Floor correction: if delta<0 and the remainder is nonzero, q0 = -(|q|+1) and r0 = (g+1) - |r|; otherwise sign the magnitude result.
  - Invariant: 0 <= r0 <= g.
- EMIT runs for k = 1..g, one write per cycle:
  - Accumulator starts at q=q0, r=r0.
  - wr_data = last + q, truncated to W; this cannot overflow because the result lies between last and next.
  - Next step: q += q0, r += r0; if r >= g+1 then r -= g+1 and q += 1.
  - Result is exactly last + floor(delta*k/(g+1)).
  - wr_addr = (base + k - 1) mod DEPTH (wraps); wr_ch = granted channel; wr_valid = 1.
  - After write k=g, go to FIN.
- FIN: pulse done[ch] for one cycle, then go to IDLE.
- Latency:
  - First wr_valid comes 18 cycles after the ack cycle.
  - done comes 1 cycle after the last write.
  - A new grant is possible in the cycle after FIN.
- req is not sampled outside IDLE. Requesters hold req (with stable operands) until ack, then deassert. A req still high in the cycle after ack is treated as a new request.
- g==0: ack, then FIN; no writes, done still pulses.
- wr_data, wr_addr and wr_ch hold their last values when wr_valid=0.

Decomposition:
- Shared package:
  - W, NCH, AW
  - DIV_CYCLES = W+1
  - state enum {IDLE, DIV, EMIT, FIN}
  - channel-index type
- Natural sub-module: serial_floor_divider.
  - Interface: start, dividend (W+1 signed), divisor (AW+1 unsigned), q, r, ready.
  - Fixed 17-cycle latency; includes the floor correction.
- Arbiter, accumulator and address generation stay in the top level.

Test Plan:
- ch0 last=100, next=200, g=3, base=2 -> ack[0]; 18 cycles later, writes (addr,data) = (2,125), (3,150), (4,175); then done[0].
- ch1 last=0, next=-10, g=2, base=0 -> writes -4 then -7 (floor semantics); done[1].
- ch2 base=6, g=4, last=0, next=50 -> addrs 6,7,0,1 with data 10,20,30,40.
- ch3 last=-32768, next=32767, g=7 -> first write -24577, last write 24575, no overflow.
- All four req high at once, held until ack -> grants in order 0,1,2,3; then ch0 and ch2 re-request -> grants 0 then 2; g==0 request -> ack then done, no wr_valid.
- Assert reset in the 2nd EMIT cycle -> all outputs 0 asynchronously, FSM IDLE; after release, the re-request from that channel is served again from k=1.
